// File: rtl/bus_arbiter_rr.sv
// Round-robin bus arbiter: holds a one-hot grant until the slave acks, then rotates priority.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_rr #(
  parameter int unsigned N       = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         bus_req,
  input  logic                 bus_ack,
  output logic [N-1:0]         bus_grant,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int unsigned IdW = $clog2(N);
  localparam logic [IdW-1:0] LastId = IdW'(N - 1);

  if (N < 2 || TIMEOUT < 4) begin : g_bad_params
    $error("bus_arbiter_rr: N must be >= 2 and TIMEOUT >= 4");
  end

  typedef enum logic {StIdle, StGranted} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IdW-1:0] id_q, id_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic           busy_q, busy_d;

  // Scan a doubled copy of the request vector so the wrap past N-1 needs no modulo.
  logic [2*N-1:0] req_2x;
  logic [IdW:0]   scan_idx;
  logic [IdW-1:0] win_id;
  logic           found;

  always_comb begin
    req_2x   = {bus_req, bus_req};
    scan_idx = '0;
    win_id   = '0;
    found    = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      scan_idx = {1'b0, ptr_q} + (IdW + 1)'(off);
      if (!found && req_2x[scan_idx]) begin
        found  = 1'b1;
        win_id = (scan_idx >= (IdW + 1)'(N)) ? IdW'(scan_idx - (IdW + 1)'(N)) : IdW'(scan_idx);
      end
    end
  end

  logic expired;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  // cnt_q holds the number of the current GRANTED cycle (1 in the first one).
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;

  assign expired = (cnt_q == CntW'(TIMEOUT));

  always_comb begin
    cnt_d = cnt_q;
    tmo_d = 1'b0;
    if (state_q == StIdle) begin
      if (|bus_req) cnt_d = CntW'(1);
    end else if (!bus_ack) begin
      if (expired) tmo_d = 1'b1;
      else         cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end

  assign timeout_err = tmo_q;
`else
  assign expired     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    unique case (state_q)
      StIdle: begin
        if (|bus_req) begin
          state_d         = StGranted;
          grant_d         = '0;
          grant_d[win_id] = 1'b1;
          id_d            = win_id;
          busy_d          = 1'b1;
        end
      end
      StGranted: begin
        // Ack takes priority over expiry; both release and rotate identically.
        if (bus_ack || expired) begin
          state_d = StIdle;
          grant_d = '0;
          id_d    = '0;
          busy_d  = 1'b0;
          ptr_d   = (id_q == LastId) ? '0 : id_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus_grant = grant_q;
  assign grant_id  = id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Bench for bus_arbiter_rr: directed scenarios plus random traffic against an integer reference model.
// Timeout scenarios follow ARB_TIMEOUT_EN.
module tb_bus_arbiter_rr;
  localparam int N       = 4;
  localparam int TIMEOUT = 16;
`ifdef ARB_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] bus_req;
  logic         bus_ack;
  logic [N-1:0] bus_grant;
  logic [1:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  always #5 clk = ~clk;

  bus_arbiter_rr #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus_req    (bus_req),
    .bus_ack    (bus_ack),
    .bus_grant  (bus_grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who holds the bus, priority pointer, cycles held.
  int m_ptr, m_id, m_cnt;
  bit m_busy, m_tmo;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input bit rs, input logic [N-1:0] r, input logic a);
    m_tmo = 1'b0;
    if (rs) begin
      m_ptr = 0; m_id = 0; m_cnt = 0; m_busy = 1'b0;
    end else if (!m_busy) begin
      if (r != '0) begin
        for (int k = 0; k < N; k++) begin
          if (r[(m_ptr + k) % N]) begin
            m_id = (m_ptr + k) % N;
            break;
          end
        end
        m_busy = 1'b1;
        m_cnt  = 1;
      end
    end else if (a || (ToEn && m_cnt == TIMEOUT)) begin
      m_tmo  = !a;
      m_busy = 1'b0;
      m_ptr  = (m_id + 1) % N;
      m_id   = 0;
    end else begin
      m_cnt++;
    end
  endtask

  // One clock: inputs present at the edge feed the model, outputs compared 1ns later.
  task automatic step(input string tag);
    logic [N-1:0] r, eg;
    logic a, rs;
    r = bus_req; a = bus_ack; rs = reset;
    @(posedge clk);
    model(rs, r, a);
    #1;
    eg = '0;
    if (m_busy) eg[m_id] = 1'b1;
    chk({tag, ".grant"}, 32'(bus_grant), 32'(eg));
    chk({tag, ".id"},    32'(grant_id),  32'(m_id));
    chk({tag, ".busy"},  32'(busy),      32'(m_busy));
    chk({tag, ".tmo"},   32'(timeout_err), 32'(m_tmo));
  endtask

  initial begin
    logic [N-1:0] rot [5];
    int hi;
    rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset with all requests held.
    reset = 1'b1; bus_req = 4'b1111; bus_ack = 1'b0;
    repeat (3) step("rst");
    chk("rst_out", 32'({bus_grant, grant_id, busy, timeout_err}), 32'(0));
    reset = 1'b0;
    step("rst_rel");
    chk("first_grant", 32'(bus_grant), 32'(4'b0001));
    bus_req = '0; bus_ack = 1'b1;
    step("rel0");
    bus_ack = 1'b0;

    // Single request with drop while granted, ack in cycle 3.
    bus_req = 4'b0100;
    step("single_c1");
    chk("single_c1_g", 32'(bus_grant), 32'(4'b0100));
    chk("single_c1_id", 32'(grant_id), 32'(2));
    bus_req = '0;
    step("single_c2");
    chk("single_c2_g", 32'(bus_grant), 32'(4'b0100));
    step("single_c3");
    chk("single_c3_g", 32'(bus_grant), 32'(4'b0100));
    bus_ack = 1'b1;
    step("single_c4");
    chk("single_c4_g", 32'(bus_grant), 32'(0));
    bus_ack = 1'b0;

    // Wrap and skip: ptr is 3, only 0 and 1 request.
    bus_req = 4'b0011;
    step("wrap_a");
    chk("wrap_first", 32'(bus_grant), 32'(4'b0001));
    step("wrap_h1");
    step("wrap_h2");
    bus_ack = 1'b1;
    step("wrap_rel");
    bus_ack = 1'b0;
    step("wrap_b");
    chk("wrap_second", 32'(bus_grant), 32'(4'b0010));
    bus_ack = 1'b1;
    step("wrap_rel2");
    bus_ack = 1'b0; bus_req = '0;

    // Stray ack in IDLE must not move the pointer (now 2).
    step("idle");
    bus_ack = 1'b1;
    step("stray");
    chk("stray_busy", 32'(busy), 32'(0));
    bus_ack = 1'b0; bus_req = 4'b1111;
    step("stray_next");
    chk("stray_next_g", 32'(bus_grant), 32'(4'b0100));
    bus_ack = 1'b1;
    step("stray_rel");
    bus_ack = 1'b0;

    // Rotation with all requests held and one idle cycle between grants.
    reset = 1'b1;
    step("rot_rst");
    reset = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step("rot_g");
      chk($sformatf("rot_grant%0d", j), 32'(bus_grant), 32'(rot[j]));
      step("rot_h1");
      step("rot_h2");
      bus_ack = 1'b1;
      step("rot_idle");
      chk($sformatf("rot_idle%0d", j), 32'(bus_grant), 32'(0));
      bus_ack = 1'b0;
    end

    // Watchdog: requester 0 never acked.
    reset = 1'b1; bus_req = '0;
    step("to_rst");
    reset = 1'b0; bus_req = 4'b0001;
    step("to_g");
    bus_req = 4'b0010;
    hi = 1;
    for (int c = 0; c < 40; c++) begin
      step("to_hold");
      if (bus_grant == '0) break;
      hi++;
    end
    if (ToEn) begin
      chk("to_len", 32'(hi), 32'(TIMEOUT));
      chk("to_err", 32'(timeout_err), 32'(1));
      step("to_next");
      chk("to_next_g", 32'(bus_grant), 32'(4'b0010));
      chk("to_err_once", 32'(timeout_err), 32'(0));
    end else begin
      chk("hold_len", 32'(hi), 32'(41));
      chk("hold_g", 32'(bus_grant), 32'(4'b0001));
    end

    // Reset mid-grant drops the grant with no timeout pulse.
    reset = 1'b1;
    step("mid_rst");
    chk("mid_rst_g", 32'(bus_grant), 32'(0));
    chk("mid_rst_tmo", 32'(timeout_err), 32'(0));
    reset = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 99) == 0);
      bus_req = N'($urandom_range(0, 15));
      bus_ack = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
